// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the parallel tx/rx and status signals of the SPI responder.
interface spi_slave_if #(parameter int DATA_W = 8);
    logic              SCLK;
    logic              CS;
    logic              MOSI;
    logic              MISO;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              underrun;
    modport slave (
        input  SCLK, CS, MOSI, tx_data, tx_valid,
        output MISO, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );
    modport master (
        output SCLK, CS, MOSI, tx_data, tx_valid,
        input  MISO, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder (mode 0, MSB first) with a one-entry tx holding
// register and a parallel rx port; all logic runs on clk.
module spi_slave #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = '0
) (
    input logic        clk,
    input logic        rst,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic sclk_d, cs_d, sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [DATA_W-1:0] tx_reg, load_word, rx_next, rx_data;
    logic [DATA_W-2:0] tx_shift, rx_shift;
    logic [CW-1:0] bit_cnt;
    logic tx_full, from_reg, word_done, miso, rx_valid, underrun;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign load_word = tx_full ? tx_reg : IDLE_FILL;
    assign rx_next   = {rx_shift, mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.SCLK};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.CS};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && cs_fall) ? ACTIVE :
                   (state == ACTIVE && cs_rise) ? IDLE : state;
    end

    // miso holds the current output bit; tx_shift holds the bits still to go
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_reg    <= '0;
            tx_full   <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            from_reg  <= 1'b0;
            word_done <= 1'b0;
            miso      <= 1'b0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            if (bus.tx_valid && !tx_full) begin
                tx_reg  <= bus.tx_data;
                tx_full <= 1'b1;
            end
            if (state == IDLE && cs_fall) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                word_done <= 1'b0;
                tx_shift  <= load_word[DATA_W-2:0];
                miso      <= load_word[DATA_W-1];
                from_reg  <= tx_full;
            end else if (state == ACTIVE && cs_rise) begin
                bit_cnt   <= '0;
                word_done <= 1'b0;
                miso      <= 1'b0;
            end else if (state == ACTIVE && sclk_rise) begin
                rx_shift <= rx_next[DATA_W-2:0];
                bit_cnt  <= (bit_cnt == CW'(DATA_W-1)) ? '0 : bit_cnt + CW'(1);
                if (bit_cnt == '0) begin
                    if (from_reg) tx_full <= 1'b0;
                    else          underrun <= 1'b1;
                end
                if (bit_cnt == CW'(DATA_W-1)) begin
                    rx_data   <= rx_next;
                    rx_valid  <= 1'b1;
                    word_done <= 1'b1;
                end
            end else if (state == ACTIVE && sclk_fall) begin
                // word boundary peeks the holding register; commit waits for the next bit 0
                tx_shift  <= word_done ? load_word[DATA_W-2:0] : tx_shift << 1;
                miso      <= word_done ? load_word[DATA_W-1] : tx_shift[DATA_W-2];
                from_reg  <= word_done ? tx_full : from_reg;
                word_done <= 1'b0;
            end
        end
    end

    assign bus.MISO     = miso;
    assign bus.miso_oe  = (state == ACTIVE);
    assign bus.busy     = (state == ACTIVE);
    assign bus.tx_ready = ~tx_full;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.underrun = underrun;
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the 8-bit SPI master in this design; the other end of the same link.
- Sits in the FPGA fabric on the system clock and oversamples the SCLK, CS and MOSI pins.
- Delivers each received byte on a parallel rx port and shifts out bytes written to a one-entry tx holding register.
- Link format: SCLK idles low, CS active-low, MSB first, master samples MISO on SCLK rising and changes MOSI on SCLK falling.

Parameters:
DATA_W, 8, bits per SPI word
SYNC_STAGES, 2, flip-flops in each pin synchronizer (minimum 2)
IDLE_FILL, 8'h00, word shifted out when the tx register is empty (width DATA_W)

Ports:
clk  in  1  system clock; each SCLK high and low phase must last at least SYNC_STAGES+2 clk periods
rst  in  1  asynchronous reset, active-low
SCLK  in  1  SPI clock from master
CS  in  1  chip select from master, active-low
MOSI  in  1  master-out data
MISO  out  1  slave-out data
miso_oe  out  1  MISO output enable; 1 while the synced CS is low
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx holding register empty
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-cycle pulse, rx_data updated
busy  out  1  frame in progress
underrun  out  1  one-cycle pulse, IDLE_FILL was committed instead of user data

Behaviour:
- Reset (rst=0, asynchronous): MISO=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0.
  - Synchronizers reset to SCLK=0, CS=1, MOSI=0.
  - tx register emptied; bit counter 0; state IDLE.
  - Reset mid-frame discards all partial data.
- Synchronize SCLK, CS and MOSI through SYNC_STAGES flops. Detect edges by comparing the synced value with a one-cycle-delayed copy. All further logic is on clk only.
- tx register:
  - tx_valid && tx_ready captures tx_data; tx_ready drops the next cycle.
  - tx_ready returns to 1 the cycle after the register is committed (see below).
  - tx_valid while tx_ready=0 is ignored.
- State machine, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on synced CS falling edge.
    - Clear bit_cnt and rx shift register.
    - Load tx shift register from the tx register if full, else IDLE_FILL.
    - MISO = tx shift MSB; busy=1, miso_oe=1.
  - ACTIVE, synced SCLK rising:
    - rx_shift <= {rx_shift, MOSI_s}; bit_cnt++.
    - If this was bit 0 of a word and the tx shift came from the tx register, commit (empty) the tx register. If it came from IDLE_FILL, pulse underrun.
    - On bit DATA_W-1: rx_data <= completed word, rx_valid=1 for one cycle, bit_cnt=0, set word_done.
  - ACTIVE, synced SCLK falling:
    - If word_done: reload the tx shift register from the tx register (peek, not commit) or IDLE_FILL, then clear word_done.
    - Else shift the tx shift register left by 1.
    - MISO follows the MSB.
  - ACTIVE -> IDLE on synced CS rising edge.
    - busy=0, miso_oe=0, MISO=0.
    - A partial word (bit_cnt≠0) is discarded, with no rx_valid.
    - A peeked-but-uncommitted tx word stays in the tx register for the next frame.
- Simultaneous events in one clk:
  - CS rising beats any SCLK edge.
  - CS falling while in ACTIVE (glitch) is ignored.
  - SCLK edges in IDLE are ignored.
- Latency: rx_valid rises SYNC_STAGES+1 clk after the raw 8th SCLK rising edge. MISO changes SYNC_STAGES+1 clk after the raw SCLK falling edge or CS falling edge.
- Multi-word frames: CS held low over N×DATA_W clocks yields N rx_valid pulses and N tx commits/underruns.

Test Plan:
1. Reset, then write tx_data=8'hA5. Master sends 8'h3C in one frame. Expect:
   - MISO bits 1,0,1,0,0,1,0,1.
   - rx_data=8'h3C with a single rx_valid pulse.
   - tx_ready back to 1 after the first SCLK rise; no underrun.
2. No tx write; master sends 8'hFF. Expect MISO all 0 (IDLE_FILL), one underrun pulse, rx_data=8'hFF.
3. 2-word frame, CS low throughout. Master sends 8'h12 then 8'h34; tx writes 8'hC3 before the frame and 8'h5A while word 1 shifts. Expect:
   - rx_valid twice with 8'h12 then 8'h34.
   - MISO carries 8'hC3 then 8'h5A.
4. CS raised after 4 SCLK rises of 8'hF0. Expect no rx_valid, busy=0, bit_cnt cleared. Next full frame of 8'h81 gives rx_data=8'h81.
5. Write 8'h77 and start a frame, then pull rst=0 after 3 bits. Expect all outputs at reset values immediately and tx_ready=1. A later frame with no tx write gives underrun.
6. tx write of 8'h99 while tx_ready=0 (register holds 8'h66). Expect 8'h66 transmitted; 8'h99 dropped.
